// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline port A and loader/DMA port B share one memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port A has fixed priority.
module dmem_arbiter #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [DATA_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  output logic              A_ACK,
  output logic              A_ERR,
  output logic [DATA_W-1:0] A_RDATA,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [DATA_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_ACK,
  output logic              B_ERR,
  output logic [DATA_W-1:0] B_RDATA,
  output logic              MEM_WRITE,
  output logic              MEM_READ,
  output logic [DATA_W-1:0] MEM_ADDR_OUT,
  output logic [DATA_W-1:0] WRITE_DATA,
  input  logic [DATA_W-1:0] MEM_DATA_IN,
  output logic              BUSY
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              a_elig, b_elig, grant, grant_b;
  logic              we_p1, sel_p1;
  logic [DATA_W-1:0] addr_p1, wdata_p1;
  logic              in_range;

`ifdef DMEM_ARB_RR_EN
  logic              last_b;
`endif

  // A port whose ACK is high this cycle has just completed and must not be re-granted.
  always_comb begin
    a_elig = A_REQ & ~A_ACK;
    b_elig = B_REQ & ~B_ACK;
    grant  = a_elig | b_elig;
`ifdef DMEM_ARB_RR_EN
    grant_b = b_elig & (~a_elig | ~last_b);
`else
    grant_b = b_elig & ~a_elig;
`endif
  end

  assign in_range = (addr_p1 < DATA_W'(DEPTH));
  assign BUSY     = (state == SERVE);

  always_comb begin
    state_nxt    = state;
    MEM_WRITE    = 1'b0;
    MEM_READ     = 1'b0;
    MEM_ADDR_OUT = '0;
    WRITE_DATA   = '0;
    case (state)
      IDLE: begin
        if (grant) state_nxt = SERVE;
      end
      SERVE: begin
        state_nxt    = IDLE;
        MEM_ADDR_OUT = addr_p1;
        WRITE_DATA   = wdata_p1;
        MEM_WRITE    = we_p1 & in_range & ~RESET;
        MEM_READ     = ~we_p1 & in_range;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: grant-time capture of the winning request
  always_ff @(posedge CLK) begin
    if (state == IDLE && grant) begin
      sel_p1   <= grant_b;
      we_p1    <= grant_b ? B_WE    : A_WE;
      addr_p1  <= grant_b ? B_ADDR  : A_ADDR;
      wdata_p1 <= grant_b ? B_WDATA : A_WDATA;
    end
  end

  // Completion: the edge leaving SERVE produces the ACK/ERR pulse and read data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      A_ACK   <= 1'b0;
      B_ACK   <= 1'b0;
      A_ERR   <= 1'b0;
      B_ERR   <= 1'b0;
      A_RDATA <= '0;
      B_RDATA <= '0;
`ifdef DMEM_ARB_RR_EN
      last_b  <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      A_ACK <= 1'b0;
      B_ACK <= 1'b0;
      A_ERR <= 1'b0;
      B_ERR <= 1'b0;
      if (state == SERVE) begin
        if (sel_p1) begin
          B_ACK <= 1'b1;
          B_ERR <= ~in_range;
          if (!we_p1) B_RDATA <= in_range ? MEM_DATA_IN : '0;
        end else begin
          A_ACK <= 1'b1;
          A_ERR <= ~in_range;
          if (!we_p1) A_RDATA <= in_range ? MEM_DATA_IN : '0;
        end
      end
`ifdef DMEM_ARB_RR_EN
      if (state == IDLE && grant) last_b <= grant_b;
`endif
    end
  end

endmodule
